// File: rtl/up_sample_affine_controller.sv
// up_sample_affine_controller
//   Iteration-domain sequencer for one op port of an up_sample unified buffer.
//   It walks a 3-deep affine loop nest and issues one strobe per iteration.
//   The strobe is spaced by the initiation interval II and is first issued
//   START_DELAY cycles after reset release or flush.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous reset, active low
//   flush      in   1        synchronous restart of the schedule
//   stall      in   1        freeze all counters for this cycle
//   valid      out  1        iteration fires this cycle (wen/ren strobe)
//   ctrl_vars  out  3 x W    loop indices, [0] outer .. [2] inner
//   done       out  1        whole domain issued, sticky until flush/reset
module up_sample_affine_controller #(
  parameter int W           = 16,
  parameter int EXT0        = 1,
  parameter int EXT1        = 64,
  parameter int EXT2        = 64,
  parameter int START_DELAY = 0,
  parameter int II          = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                stall,
  output logic                valid,
  output logic [2:0][W-1:0]   ctrl_vars,
  output logic                done
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_RUN,
    S_DONE
  } state_t;

  // With no start delay the schedule begins issuing straight out of reset.
  localparam state_t INIT_STATE = (START_DELAY == 0) ? S_RUN : S_WAIT;

  // When START_DELAY is 0 this wraps to all ones, but WAIT is never entered then.
  localparam logic [W-1:0] LAST_DELAY = W'(START_DELAY - 1);
  localparam logic [W-1:0] II_LAST    = W'(II - 1);
  localparam logic [W-1:0] LAST0      = W'(EXT0 - 1);
  localparam logic [W-1:0] LAST1      = W'(EXT1 - 1);
  localparam logic [W-1:0] LAST2      = W'(EXT2 - 1);

  state_t            state, state_nxt;
  logic [W-1:0]      delay_cnt, delay_nxt;
  logic [W-1:0]      ii_cnt, ii_nxt;
  logic [2:0][W-1:0] vars_nxt;
  logic              fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_STATE;
      delay_cnt <= '0;
      ii_cnt    <= '0;
      ctrl_vars <= '0;
    end else begin
      state     <= state_nxt;
      delay_cnt <= delay_nxt;
      ii_cnt    <= ii_nxt;
      ctrl_vars <= vars_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    delay_nxt = delay_cnt;
    ii_nxt    = ii_cnt;
    vars_nxt  = ctrl_vars;
    fire      = (state == S_RUN) && (ii_cnt == '0) && !stall;

    case (state)
      S_WAIT: begin
        if (!stall) begin
          delay_nxt = delay_cnt + W'(1);
          if (delay_cnt == LAST_DELAY) state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) ii_nxt = (ii_cnt == II_LAST) ? '0 : ii_cnt + W'(1);
        if (fire) begin
          // Row-major odometer; the final iteration parks the indices at zero.
          if (ctrl_vars[0] == LAST0 && ctrl_vars[1] == LAST1 && ctrl_vars[2] == LAST2) begin
            state_nxt = S_DONE;
            vars_nxt  = '0;
          end else if (ctrl_vars[2] != LAST2) begin
            vars_nxt[2] = ctrl_vars[2] + W'(1);
          end else begin
            vars_nxt[2] = '0;
            if (ctrl_vars[1] != LAST1) begin
              vars_nxt[1] = ctrl_vars[1] + W'(1);
            end else begin
              vars_nxt[1] = '0;
              vars_nxt[0] = ctrl_vars[0] + W'(1);
            end
          end
        end
      end
      default: ;
    endcase

    // Flush wins over stall and over a fire in the same cycle; the strobe of
    // the flush cycle itself is still issued.
    if (flush) begin
      state_nxt = INIT_STATE;
      delay_nxt = '0;
      ii_nxt    = '0;
      vars_nxt  = '0;
    end

    // Gating with rst_n keeps the strobe low while reset is held, even though
    // the reset state may already be RUN with ii_cnt at zero.
    valid = fire && rst_n;
    done  = (state == S_DONE);
  end

endmodule

// File: tb/tb_up_sample_affine_controller.sv
// tb_up_sample_affine_controller
//   Drives two controller instances with different schedules from shared
//   stimulus and compares them against a schedule-level reference model.
//   The model counts unstalled cycles since restart and the iterations
//   issued so far.
module tb_up_sample_affine_controller;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic stall = 1'b0;

  logic              valid_a, valid_b;
  logic              done_a, done_b;
  logic [2:0][W-1:0] vars_a, vars_b;

  int errors = 0;
  int checks = 0;

  // Reference parameters: index 0 is instance a, index 1 is instance b.
  int ext0[2]  = '{1, 2};
  int ext1[2]  = '{4, 3};
  int ext2[2]  = '{4, 3};
  int dly[2]   = '{0, 5};
  int iiv[2]   = '{1, 3};

  // Model state: unstalled cycles since restart and iterations issued so far.
  int t[2];
  int n[2];
  logic fireExp[2];

  always #5 clk = ~clk;

  up_sample_affine_controller #(
    .W(W), .EXT0(1), .EXT1(4), .EXT2(4), .START_DELAY(0), .II(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .valid(valid_a), .ctrl_vars(vars_a), .done(done_a)
  );

  up_sample_affine_controller #(
    .W(W), .EXT0(2), .EXT1(3), .EXT2(3), .START_DELAY(5), .II(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .valid(valid_b), .ctrl_vars(vars_b), .done(done_b)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int total(input int k);
    return ext0[k] * ext1[k] * ext2[k];
  endfunction

  // Iteration n fires once the delay has elapsed and the interval phase is zero.
  function automatic logic modelFire(input int k);
    if (!rst_n || stall || n[k] >= total(k)) return 1'b0;
    if (t[k] < dly[k]) return 1'b0;
    return ((t[k] - dly[k]) % iiv[k]) == 0;
  endfunction

  function automatic logic [2:0][W-1:0] modelVars(input int k);
    logic [2:0][W-1:0] e;
    e = '0;
    if (rst_n && n[k] < total(k)) begin
      e[0] = W'(n[k] / (ext1[k] * ext2[k]));
      e[1] = W'((n[k] / ext2[k]) % ext1[k]);
      e[2] = W'(n[k] % ext2[k]);
    end
    return e;
  endfunction

  function automatic logic modelDone(input int k);
    return rst_n && (n[k] == total(k));
  endfunction

  task automatic checkInstance(input int k, input logic v, input logic [2:0][W-1:0] cv, input logic d);
    checkOutput($sformatf("valid[%0d]", k), 64'(v), 64'(modelFire(k)));
    checkOutput($sformatf("ctrl_vars[%0d]", k), 64'(cv), 64'(modelVars(k)));
    checkOutput($sformatf("done[%0d]", k), 64'(d), 64'(modelDone(k)));
  endtask

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      t[k] = 0;
      n[k] = 0;
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check mid-cycle,
  // then advance the model across the rising edge.
  task automatic applyStimulus(input logic st, input logic fl);
    @(negedge clk);
    rst_n = 1'b1;
    stall = st;
    flush = fl;
    #1;
    checkInstance(0, valid_a, vars_a, done_a);
    checkInstance(1, valid_b, vars_b, done_b);
    for (int k = 0; k < 2; k++) fireExp[k] = modelFire(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (fl) begin
        t[k] = 0;
        n[k] = 0;
      end else if (!st) begin
        if (fireExp[k]) n[k]++;
        t[k]++;
      end
    end
  endtask

  // Asynchronous reset dropped between clock edges; outputs must clear at once.
  task automatic asyncReset(input int offset);
    #(offset);
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    resetModel();
    #1;
    checkInstance(0, valid_a, vars_a, done_a);
    checkInstance(1, valid_b, vars_b, done_b);
    repeat (2) @(posedge clk);
    #1;
    checkInstance(0, valid_a, vars_a, done_a);
    checkInstance(1, valid_b, vars_b, done_b);
  endtask

  initial begin
    resetModel();
    asyncReset(3);

    // Clean run: both domains issue completely and done goes sticky.
    for (int c = 0; c < 70; c++) applyStimulus(1'b0, 1'b0);

    // Restart, then stall on cycles 2..4 of the new schedule.
    applyStimulus(1'b0, 1'b1);
    for (int c = 0; c < 30; c++) applyStimulus(c >= 2 && c <= 4, 1'b0);

    // Flush exactly on the cycle iteration 7 of instance a fires.
    applyStimulus(1'b0, 1'b1);
    for (int c = 0; c < 7; c++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 1'b0);

    // Random stalls and occasional flushes.
    for (int c = 0; c < 400; c++)
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0);

    // Abort mid-run with an asynchronous reset, then replay a clean schedule.
    applyStimulus(1'b0, 1'b1);
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b0);
    asyncReset(7);
    for (int c = 0; c < 70; c++) applyStimulus(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
